div: RTL and testbench

Iterative 32-bit radix-2 restoring divider for the EX stage; the sequential counterpart of the pipelined multiplier. Serves DIV/DIVU, producing {remainder, quotient} for the HI/LO write path. It holds the pipeline with a stall request while busy, and is aborted by the same flush conditions that clear the multiplier's pipeline registers.

---
 rtl/div.sv | 133 +++++++++++++
 tb/tb_div.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// rtl/div.sv - iterative 32-bit radix-2 restoring divider with stall and abort handling
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        flush_cause,
  input  logic        ex_issue_mode_i,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] z,
  output logic        ready,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, BYZERO, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;        // {remainder, dividend/quotient}
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] x_q, x_d;            // raw dividend, returned as remainder on divide-by-zero
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] z_q, z_d;

  logic        abort;
  logic [31:0] abs_x, abs_y;
  logic [32:0] upper;
  logic        ge;
  logic [31:0] rem_next;
  logic [63:0] step;
  logic [31:0] q_fix, r_fix;

  // Exceptions always kill the operation; a mispredict only does so in dual issue.
  assign abort = annul | (flush & (flush_cause | ex_issue_mode_i));

  assign abs_x = (signed_div && x[31]) ? (~x + 32'd1) : x;
  assign abs_y = (signed_div && y[31]) ? (~y + 32'd1) : y;

  // One restoring step: the upper 33 bits of the left-shifted 65-bit {rem, dividend}
  // register are acc_q[63:31]; a successful subtract always leaves a 32-bit remainder.
  assign upper    = acc_q[63:31];
  assign ge       = upper >= {1'b0, divisor_q};
  assign rem_next = ge ? (upper[31:0] - divisor_q) : upper[31:0];
  assign step     = {rem_next, acc_q[30:0], ge};

  assign q_fix = qneg_q ? (~step[31:0] + 32'd1) : step[31:0];
  assign r_fix = rneg_q ? (~step[63:32] + 32'd1) : step[63:32];

  assign z     = z_q;
  assign ready = (state_q == DONE);

  // Stall from the accepting IDLE cycle until the result is presented.
  assign stall_req = ((state_q == IDLE) && start && !abort) ||
                     (state_q == BUSY) || (state_q == BYZERO);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    x_d       = x_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    z_d       = z_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          x_d = x;
          if (y != 32'd0) begin
            state_d   = BUSY;
            acc_d     = {32'd0, abs_x};
            divisor_d = abs_y;
            qneg_d    = signed_div & (x[31] ^ y[31]);
            rneg_d    = signed_div & x[31];
            count_d   = 6'd0;
          end else begin
            state_d = BYZERO;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + 6'd1;
          if (count_q == 6'd31) begin
            state_d = DONE;
            z_d     = {r_fix, q_fix};
          end
        end
      end
      BYZERO: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          z_d     = {x_q, 32'hFFFF_FFFF};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 6'd0;
      acc_q     <= 64'd0;
      divisor_q <= 32'd0;
      x_q       <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      z_q       <= 64'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      x_q       <= x_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      z_q       <= z_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for the iterative divider
module tb_div;
  logic        clk = 1'b0;
  logic        rst, flush, flush_cause, ex_issue_mode_i, start, annul, signed_div;
  logic [31:0] x, y;
  logic [63:0] z;
  logic        ready, stall_req;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_z = 64'd0;

  div dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
    .ex_issue_mode_i(ex_issue_mode_i), .start(start), .annul(annul),
    .signed_div(signed_div), .x(x), .y(y), .z(z), .ready(ready), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Reference: architectural DIV/DIVU results from plain arithmetic.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Issues one operation and observes until one cycle past ready (cycle 0 = start cycle).
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int rc, output logic [63:0] zr, output int nready, output int stall_bad);
    rc = -1; zr = 64'd0; nready = 0; stall_bad = 0;
    @(negedge clk);
    signed_div = sd; x = a; y = b; start = 1'b1;
    #1;
    if (!stall_req) stall_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready) begin
        nready++;
        if (rc < 0) begin rc = c; zr = z; end
      end
      if (rc < 0 && !stall_req) stall_bad++;
      if (rc >= 0 && stall_req) stall_bad++;
      if (rc >= 0 && c == rc + 1) break;
    end
  endtask

  task automatic check_op(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_rc);
    int rc, nr, sb;
    logic [63:0] zr, ez;
    ez = model(sd, a, b);
    run_div(sd, a, b, rc, zr, nr, sb);
    checks++;
    if (rc !== exp_rc) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, rc, exp_rc); end
    checks++;
    if (zr !== ez) begin errors++; $display("FAIL %s z: got %h want %h", name, zr, ez); end
    checks++;
    if (nr !== 1) begin errors++; $display("FAIL %s ready pulses: got %0d want 1", name, nr); end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL %s stall_req profile: %0d bad cycles want 0", name, sb); end
    last_z = ez;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; flush_cause = 0; ex_issue_mode_i = 0; start = 0; annul = 0;
    signed_div = 0; x = 0; y = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (z !== 64'd0) begin errors++; $display("FAIL reset z: got %h want 0", z); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", ready); end
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL reset stall_req: got %b want 0", stall_req); end
  endtask

  task automatic test_directed();
    check_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 33);
    checks++;
    if (last_z !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7 model: got %h want %h", last_z, {32'd2, 32'd14}); end
    check_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
    check_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
    check_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    check_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33);
    check_op("udiv_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_divzero();
    check_op("divzero_s", 1'b1, 32'h1234_5678, 32'd0, 2);
    check_op("divzero_u", 1'b0, 32'h1234_5678, 32'd0, 2);
    checks++;
    if (z !== {32'h1234_5678, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divzero hold: got %h want %h", z, {32'h1234_5678, 32'hFFFF_FFFF}); end
  endtask

  // kind: 0 exception flush, 1 annul, 2 mispredict dual issue, 3 mispredict single issue
  task automatic test_abort(input int kind);
    int nr, rc;
    logic [63:0] ez;
    ez = model(1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    signed_div = 0; x = 32'd1000; y = 32'd3; start = 1'b1;
    rc = -1; nr = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) begin
        case (kind)
          0: begin flush = 1; flush_cause = 1; ex_issue_mode_i = 0; end
          1: annul = 1;
          2: begin flush = 1; flush_cause = 0; ex_issue_mode_i = 1; end
          default: begin flush = 1; flush_cause = 0; ex_issue_mode_i = 0; end
        endcase
      end else begin
        flush = 0; flush_cause = 0; ex_issue_mode_i = 0; annul = 0;
      end
      #1;
      if (ready) begin nr++; if (rc < 0) rc = c; end
      if (c == 11 && kind < 3) begin
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL abort%0d stall_req: got %b want 0", kind, stall_req); end
        checks++;
        if (z !== last_z) begin errors++; $display("FAIL abort%0d z: got %h want %h", kind, z, last_z); end
      end
    end
    if (kind < 3) begin
      checks++;
      if (nr !== 0) begin errors++; $display("FAIL abort%0d ready pulses: got %0d want 0", kind, nr); end
    end else begin
      checks++;
      if (rc !== 33 || nr !== 1) begin errors++; $display("FAIL bp_single ready: cycle %0d pulses %0d want 33/1", rc, nr); end
      checks++;
      if (z !== ez) begin errors++; $display("FAIL bp_single z: got %h want %h", z, ez); end
      last_z = ez;
    end
  endtask

  task automatic test_idle_block();
    int nr = 0;
    @(negedge clk);
    x = 32'd9; y = 32'd0; start = 1; annul = 1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_block stall_req: got %b want 0", stall_req); end
    @(negedge clk);
    annul = 0; flush = 1; flush_cause = 1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_block_flush stall_req: got %b want 0", stall_req); end
    @(negedge clk);
    start = 0; flush = 0; flush_cause = 0;
    repeat (4) begin @(negedge clk); #1; if (ready) nr++; end
    checks++;
    if (nr !== 0 || z !== last_z) begin errors++; $display("FAIL idle_block result: pulses %0d z %h want 0 %h", nr, z, last_z); end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    signed_div = 1; x = 32'hFFFF_0000; y = 32'd77; start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      rst = (c == 5);
    end
    #1;
    checks++;
    if (z !== 64'd0 || ready !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid: z %h ready %b stall %b want 0 0 0", z, ready, stall_req);
    end
    check_op("after_rst", 1'b1, 32'hFFFF_0000, 32'd77, 33);
  endtask

  task automatic test_back_to_back();
    logic [31:0] as [3], bs [3];
    int cyc [3];
    int k = 0;
    as[0] = 32'd1000; bs[0] = 32'd10;
    as[1] = 32'hDEAD_BEEF; bs[1] = 32'h1234;
    as[2] = 32'd7; bs[2] = 32'd9;
    @(negedge clk);
    signed_div = 0; x = as[0]; y = bs[0]; start = 1;
    for (int c = 1; c <= 120 && k < 3; c++) begin
      @(negedge clk);
      #1;
      if (ready) begin
        cyc[k] = c;
        checks++;
        if (z !== model(1'b0, as[k], bs[k])) begin errors++; $display("FAIL b2b%0d z: got %h want %h", k, z, model(1'b0, as[k], bs[k])); end
        last_z = model(1'b0, as[k], bs[k]);
        k++;
        if (k < 3) begin x = as[k]; y = bs[k]; end else start = 0;
      end
    end
    start = 0;
    checks++;
    if (k !== 3) begin errors++; $display("FAIL b2b count: got %0d want 3", k); end
    else begin
      checks++;
      if (cyc[1] - cyc[0] !== 34 || cyc[2] - cyc[1] !== 34) begin
        errors++; $display("FAIL b2b spacing: got %0d %0d want 34 34", cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sd;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom;
      sd = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      check_op("random", sd, a, b, (b == 32'd0) ? 2 : 33);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    for (int k = 0; k < 4; k++) test_abort(k);
    test_idle_block();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
